// File: rtl/apg_pkg.sv
// Shared types and constants for the arbitrary pattern generator.
//   apg_state_t : sequencer state, encoding is visible on status[1:0]
//   ERR_*       : bit positions inside the sticky error vector
//   TRIG_*      : trig_mode encodings
package apg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } apg_state_t;

  localparam int ERR_WR  = 0;  // write dropped (buffer full or busy)
  localparam int ERR_RD  = 1;  // read attempted while busy
  localparam int ERR_LEN = 2;  // run requested with zero-length pattern

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  localparam logic [1:0] TRIG_HIGH = 2'd3;

endpackage

// File: rtl/apg_tick_gen.sv
// Sample-rate divider. Produces a one-cycle tick every clk_div_i+1 cycles
// while enabled; the first tick occurs in the cycle after a clear.
//   clr_i     : synchronous clear of the divider count
//   en_i      : count enable, also gates the tick
//   clk_div_i : period minus one
//   tick_o    : sample strobe
module apg_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             axi_clk,
  input  logic             axi_resetn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] clk_div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == clk_div_i) ? '0 : cnt_q + DIV_W'(1);
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/arb_pattern_gen_v2.sv
// Arbitrary pattern generator: plays a stored stimulus buffer onto
// output_signals at a divided sample rate while capturing input_signals
// into a second buffer at the same index.
//   run/abort/clear          : control strobes (abort/clear win over run)
//   wr_data/wr_strobe        : append one sample to the stimulus buffer
//   rd_strobe/rd_data        : fetch the next captured sample
//   defaults                 : output value outside RUN
//   n_samples/n_loops/clk_div: pattern length, pass count (0=forever), period-1
//   trig_mode/ext_trig       : start condition
//   write_len/rd_ptr/sample_count/loops_done/status/error : readback
module arb_pattern_gen_v2
  import apg_pkg::*;
#(
  parameter int OUT_W = 14,
  parameter int IN_W  = 14,
  parameter int DEPTH = 128,
  parameter int DIV_W = 16
) (
  input  logic             axi_clk,
  input  logic             axi_resetn,
  input  logic             run,
  input  logic             abort,
  input  logic             clear,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             wr_strobe,
  input  logic             rd_strobe,
  output logic [IN_W-1:0]  rd_data,
  input  logic [OUT_W-1:0] defaults,
  input  logic [31:0]      n_samples,
  input  logic [15:0]      n_loops,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [1:0]       trig_mode,
  input  logic             ext_trig,
  input  logic [IN_W-1:0]  input_signals,
  output logic [OUT_W-1:0] output_signals,
  output logic [31:0]      write_len,
  output logic [31:0]      rd_ptr,
  output logic [31:0]      sample_count,
  output logic [15:0]      loops_done,
  output logic [2:0]       status,
  output logic [2:0]       error
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  apg_state_t       state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  rd_data_q, rd_data_d;
  logic [31:0]      write_len_q, write_len_d;
  logic [31:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]      sample_cnt_q, sample_cnt_d;
  logic [15:0]      loops_q, loops_d;
  logic [2:0]       err_q, err_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [31:0]      len_q, len_d;
  // Last sample of a finished pattern still owes its full sample period.
  logic             tail_q, tail_d;
  logic             wr_prev_q, rd_prev_q;
  logic             trig_s1_q, trig_s2_q, trig_s3_q;

  logic [OUT_W-1:0] wbuf [DEPTH];
  logic [IN_W-1:0]  rbuf [DEPTH];
  logic             wbuf_we, rbuf_we;

  logic        busy, stop, wr_rise, rd_rise, trig_hit;
  logic        tick, sample_tick, last, div_en, div_clr;
  logic [31:0] run_len;
  logic [15:0] loops_inc;

  assign busy        = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign stop        = abort || clear;
  assign wr_rise     = wr_strobe && !wr_prev_q;
  assign rd_rise     = rd_strobe && !rd_prev_q;
  assign run_len     = (n_samples > DEPTH32) ? DEPTH32 : n_samples;
  assign sample_tick = tick && (state_q == ST_RUN);
  assign last        = (ptr_q == len_q - 32'd1);
  assign loops_inc   = (loops_q == 16'hFFFF) ? loops_q : loops_q + 16'd1;

  always_comb begin
    unique case (trig_mode)
      TRIG_IMM:  trig_hit = 1'b1;
      TRIG_RISE: trig_hit = trig_s2_q && !trig_s3_q;
      TRIG_FALL: trig_hit = !trig_s2_q && trig_s3_q;
      default:   trig_hit = trig_s2_q;
    endcase
  end

  // The divider keeps running through the tail so the final sample
  // lasts exactly one period; it restarts from zero on every RUN entry.
  assign div_en  = (state_q == ST_RUN) || tail_q;
  assign div_clr = !div_en || ((state_q != ST_RUN) && (state_d == ST_RUN));

  apg_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .axi_clk   (axi_clk),
    .axi_resetn(axi_resetn),
    .clr_i     (div_clr),
    .en_i      (div_en),
    .clk_div_i (clk_div),
    .tick_o    (tick)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    rd_data_d    = rd_data_q;
    write_len_d  = write_len_q;
    rd_ptr_d     = rd_ptr_q;
    sample_cnt_d = sample_cnt_q;
    loops_d      = loops_q;
    err_d        = err_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    tail_d       = tail_q;
    wbuf_we      = 1'b0;
    rbuf_we      = 1'b0;

    if (wr_rise) begin
      if (busy || write_len_q >= DEPTH32) begin
        err_d[ERR_WR] = 1'b1;
      end else begin
        wbuf_we     = 1'b1;
        write_len_d = write_len_q + 32'd1;
      end
    end

    if (rd_rise) begin
      if (busy) begin
        err_d[ERR_RD] = 1'b1;
      end else if (rd_ptr_q < DEPTH32) begin
        rd_data_d = rbuf[rd_ptr_q[AW-1:0]];
        rd_ptr_d  = rd_ptr_q + 32'd1;
      end else begin
        rd_data_d = '0;
      end
    end

    if (stop) begin
      state_d = ST_IDLE;
      out_d   = defaults;
      tail_d  = 1'b0;
      if (clear) begin
        wbuf_we      = 1'b0;
        write_len_d  = '0;
        rd_ptr_d     = '0;
        err_d        = '0;
        sample_cnt_d = '0;
        rd_data_d    = '0;
        ptr_d        = '0;
      end
    end else begin
      if (state_q != ST_RUN) begin
        if (!tail_q) begin
          out_d = defaults;
        end else if (tick) begin
          out_d  = defaults;
          tail_d = 1'b0;
        end
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (run) begin
            if (run_len == '0) begin
              err_d[ERR_LEN] = 1'b1;
            end else begin
              sample_cnt_d = '0;
              loops_d      = '0;
              ptr_d        = '0;
              len_d        = run_len;
              tail_d       = 1'b0;
              state_d      = (trig_mode == TRIG_IMM) ? ST_RUN : ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (trig_hit) state_d = ST_RUN;
        end
        default: begin  // ST_RUN
          if (sample_tick) begin
            out_d        = wbuf[ptr_q[AW-1:0]];
            rbuf_we      = 1'b1;
            sample_cnt_d = sample_cnt_q + 32'd1;
            if (last) begin
              loops_d = loops_inc;
              if (n_loops != '0 && loops_inc == n_loops) begin
                state_d  = ST_DONE;
                rd_ptr_d = '0;
                tail_d   = 1'b1;
              end else begin
                ptr_d = '0;
              end
            end else begin
              ptr_d = ptr_q + 32'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      rd_data_q    <= '0;
      write_len_q  <= '0;
      rd_ptr_q     <= '0;
      sample_cnt_q <= '0;
      loops_q      <= '0;
      err_q        <= '0;
      ptr_q        <= '0;
      len_q        <= '0;
      tail_q       <= 1'b0;
      wr_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b0;
      trig_s1_q    <= 1'b0;
      trig_s2_q    <= 1'b0;
      trig_s3_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      rd_data_q    <= rd_data_d;
      write_len_q  <= write_len_d;
      rd_ptr_q     <= rd_ptr_d;
      sample_cnt_q <= sample_cnt_d;
      loops_q      <= loops_d;
      err_q        <= err_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      tail_q       <= tail_d;
      wr_prev_q    <= wr_strobe;
      rd_prev_q    <= rd_strobe;
      trig_s1_q    <= ext_trig;
      trig_s2_q    <= trig_s1_q;
      trig_s3_q    <= trig_s2_q;
    end
  end

  // NOTE: the sample buffers have no reset so they map onto RAM, and their
  // contents survive a reset for replay.
  always_ff @(posedge axi_clk) begin
    if (wbuf_we) wbuf[write_len_q[AW-1:0]] <= wr_data;
    if (rbuf_we) rbuf[ptr_q[AW-1:0]]       <= input_signals;
  end

  assign output_signals = out_q;
  assign rd_data        = rd_data_q;
  assign write_len      = write_len_q;
  assign rd_ptr         = rd_ptr_q;
  assign sample_count   = sample_cnt_q;
  assign loops_done     = loops_q;
  assign status         = {busy, state_q};
  assign error          = err_q;

endmodule

// File: tb/tb_arb_pattern_gen_v2.sv
// Directed self-checking bench for arb_pattern_gen_v2 (DEPTH reduced to 8).
module tb_arb_pattern_gen_v2;

  localparam int          OUT_W = 14;
  localparam int          IN_W  = 14;
  localparam int          DEPTH = 8;
  localparam int          DIV_W = 16;
  localparam logic [13:0] DEF   = 14'h2AAA;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_ARMED = 3'b101;
  localparam logic [2:0] S_RUN   = 3'b110;
  localparam logic [2:0] S_DONE  = 3'b011;

  logic             axi_clk = 1'b0;
  logic             axi_resetn;
  logic             run, abort, clear;
  logic [OUT_W-1:0] wr_data;
  logic             wr_strobe, rd_strobe;
  logic [IN_W-1:0]  rd_data;
  logic [OUT_W-1:0] defaults;
  logic [31:0]      n_samples;
  logic [15:0]      n_loops;
  logic [DIV_W-1:0] clk_div;
  logic [1:0]       trig_mode;
  logic             ext_trig;
  logic [IN_W-1:0]  input_signals;
  logic [OUT_W-1:0] output_signals;
  logic [31:0]      write_len, rd_ptr, sample_count;
  logic [15:0]      loops_done;
  logic [2:0]       status, error;

  int n_checks = 0;
  int n_fail   = 0;

  arb_pattern_gen_v2 #(
    .OUT_W(OUT_W), .IN_W(IN_W), .DEPTH(DEPTH), .DIV_W(DIV_W)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_resetn    (axi_resetn),
    .run           (run),
    .abort         (abort),
    .clear         (clear),
    .wr_data       (wr_data),
    .wr_strobe     (wr_strobe),
    .rd_strobe     (rd_strobe),
    .rd_data       (rd_data),
    .defaults      (defaults),
    .n_samples     (n_samples),
    .n_loops       (n_loops),
    .clk_div       (clk_div),
    .trig_mode     (trig_mode),
    .ext_trig      (ext_trig),
    .input_signals (input_signals),
    .output_signals(output_signals),
    .write_len     (write_len),
    .rd_ptr        (rd_ptr),
    .sample_count  (sample_count),
    .loops_done    (loops_done),
    .status        (status),
    .error         (error)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic write_sample(input logic [OUT_W-1:0] v);
    wr_data = v; wr_strobe = 1'b1; step();
    wr_strobe = 1'b0; step();
  endtask

  task automatic read_sample(output logic [IN_W-1:0] v);
    rd_strobe = 1'b1; step();
    v = rd_data;
    rd_strobe = 1'b0; step();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IN_W-1:0] rv;
    int waited;

    axi_resetn = 1'b0;
    run = 0; abort = 0; clear = 0;
    wr_data = '0; wr_strobe = 0; rd_strobe = 0;
    defaults = DEF; n_samples = 4; n_loops = 1; clk_div = 0;
    trig_mode = 2'd0; ext_trig = 0; input_signals = '0;

    #2;
    check("rst_out", output_signals, 0);
    check("rst_status", status, S_IDLE);
    step(3);
    axi_resetn = 1'b1;
    step(2);
    check("idle_out", output_signals, DEF);
    check("idle_err", error, 0);
    check("idle_wlen", write_len, 0);

    // Single pass, full rate.
    for (int v = 1; v <= 4; v++) write_sample(OUT_W'(v));
    check("t1_wlen", write_len, 4);
    pulse_run();
    check("t1_status_run", status, S_RUN);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_out", output_signals, k + 1);
    end
    step();
    check("t1_out_def", output_signals, DEF);
    check("t1_status_done", status, S_DONE);
    check("t1_loops", loops_done, 1);
    check("t1_count", sample_count, 4);

    // Divided rate: each value for 3 cycles, distinct capture per sample.
    clk_div = 2;
    pulse_run();
    for (int k = 0; k < 4; k++) begin
      input_signals = IN_W'(16 + k);
      for (int j = 0; j < 3; j++) begin
        step();
        check("t2_out", output_signals, k + 1);
      end
    end
    step();
    check("t2_out_def", output_signals, DEF);
    check("t2_status_done", status, S_DONE);
    check("t2_rdptr0", rd_ptr, 0);
    for (int k = 0; k < 4; k++) begin
      read_sample(rv);
      check("t2_rd", rv, 16 + k);
    end
    for (int k = 4; k < DEPTH; k++) read_sample(rv);
    check("t2_rdptr_full", rd_ptr, DEPTH);
    read_sample(rv);
    check("t2_rd_past_end", rv, 0);
    check("t2_rdptr_sat", rd_ptr, DEPTH);

    // Three passes of a two-sample pattern.
    clk_div = 0; n_samples = 2; n_loops = 3;
    pulse_run();
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_out", output_signals, (k % 2) + 1);
    end
    step();
    check("t3_out_def", output_signals, DEF);
    check("t3_loops", loops_done, 3);
    check("t3_status_done", status, S_DONE);

    // Infinite looping until abort; counters keep their values.
    n_loops = 0;
    pulse_run();
    step(9);
    check("t4_status_run", status, S_RUN);
    pulse_abort();
    check("t4_status_idle", status, S_IDLE);
    check("t4_out_def", output_signals, DEF);
    check("t4_loops_kept", loops_done, 4);
    check("t4_count_kept", sample_count, 9);

    // External trigger, rising edge then level-high.
    trig_mode = 2'd1; n_samples = 4; n_loops = 1;
    pulse_run();
    check("t5_armed", status, S_ARMED);
    step(10);
    check("t5_still_armed", status, S_ARMED);
    ext_trig = 1'b1;
    waited = 0;
    while (status != S_RUN && waited < 6) begin
      step();
      waited++;
    end
    check("t5_rise_latency", waited, 3);
    pulse_abort();
    trig_mode = 2'd3;
    pulse_run();
    check("t5_high_armed", status, S_ARMED);
    step();
    check("t5_high_run", status, S_RUN);
    pulse_abort();
    check("t5_abort_idle", status, S_IDLE);
    ext_trig = 1'b0; trig_mode = 2'd0;

    // Error flags and clear.
    pulse_clear();
    check("t6_clr_wlen", write_len, 0);
    wr_data = 14'd1; wr_strobe = 1'b1; step(4);
    wr_strobe = 1'b0; step();
    check("t6_held_strobe", write_len, 1);
    for (int v = 2; v <= DEPTH + 1; v++) write_sample(OUT_W'(v));
    check("t6_wlen_full", write_len, DEPTH);
    check("t6_err_wr", error, 3'b001);
    n_samples = 0;
    pulse_run();
    check("t6_err_len", error, 3'b101);
    check("t6_len0_idle", status, S_IDLE);
    n_samples = 2; n_loops = 0;
    pulse_run();
    rd_strobe = 1'b1; step(); rd_strobe = 1'b0; step();
    check("t6_err_rd", error, 3'b111);
    check("t6_rd_busy_run", status, S_RUN);
    pulse_clear();
    check("t6_clr_err", error, 0);
    check("t6_clr_status", status, S_IDLE);
    check("t6_clr_count", sample_count, 0);
    check("t6_clr_rdptr", rd_ptr, 0);
    check("t6_clr_rddata", rd_data, 0);

    // Reset mid-RUN, then replay the buffer written before reset.
    n_samples = 4; n_loops = 1;
    pulse_run();
    step(2);
    #2;
    axi_resetn = 1'b0;
    #1;
    check("t7_rst_out", output_signals, 0);
    check("t7_rst_status", status, S_IDLE);
    step(2);
    axi_resetn = 1'b1;
    step();
    pulse_run();
    for (int k = 0; k < 4; k++) begin
      step();
      check("t7_replay", output_signals, k + 1);
    end
    step();
    check("t7_out_def", output_signals, DEF);
    check("t7_status_done", status, S_DONE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
